boot_loader: RTL and testbench
==============================

// Module: boot_loader
// PURPOSE
//  Byte-stream firmware loader that fills dp_ram before the core runs; sits upstream of riscv_top.
//  Consumes bytes from a UART RX (valid/ready), assembles little-endian 32-bit words and writes them
//  through a RAM write port. It holds the core in reset until the image and checksum are accepted.
//  Synthesisable replacement for the simulation-only writeWord backdoor.
// PARAMETERS
//  ADDR_W     32       byte-address width of mem_addr
//  BASE_ADDR  32'h0    byte address of first loaded word
//  MAX_WORDS  4096     largest accepted image, in words; larger header -> ERR
//  TIMEOUT    1000000  max idle cycles between bytes once a frame has started; 0 disables
// PORTS
//  clk          in   1       clock
//  rst          in   1       synchronous reset, active-high
//  boot_bypass  in   1       sampled the cycle rst deasserts; 1 -> go straight to DONE
//  in_valid     in   1       byte available from UART RX
//  in_data      in   8       received byte
//  in_ready     out  1       loader accepts in_data this cycle (transfer = in_valid & in_ready)
//  mem_we       out  1       one-cycle word write strobe to dp_ram
//  mem_addr     out  ADDR_W  byte address, word aligned
//  mem_wdata    out  32      word to write
//  core_rst_n   out  1       reset to riscv_top; low holds the core
//  done         out  1       image loaded and checksum OK (sticky)
//  err          out  1       length, checksum or timeout failure (sticky)
// BEHAVIOUR
//  Reset: state=HDR, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, core_rst_n=0, done=0, err=0.
//   The byte counter, word counter, checksum and idle timer are all cleared.
//   rst asserted at any time, including mid-frame, aborts the load and re-holds the core.
//  Frame format: 4 header bytes (N = word count, LE) -> 4*N payload bytes -> 1 checksum byte.
//  Checksum: 8-bit sum of all header, payload and checksum bytes must be 0 mod 256.
//  Byte order: the first byte of each group goes to bits [7:0], the 4th to bits [31:24].
//  in_ready=1 in HDR, DATA and SUM; 0 in DONE and ERR. The RAM port never stalls.
//  States:
//   HDR: shift in 4 bytes. After the 4th: N>MAX_WORDS -> ERR; N==0 -> SUM; else -> DATA.
//   DATA: on the 4th byte of word i (i=0..N-1), register mem_we=1, mem_addr=BASE_ADDR+4*i and
//    mem_wdata on the next cycle, for exactly one cycle. After word N-1 -> SUM.
//   SUM: accept one byte. Total==0 -> DONE, else -> ERR. The state change takes effect next cycle.
//   DONE: core_rst_n=1 and done=1 from the first DONE cycle; stays until rst.
//    The final mem_we always precedes or coincides with that first cycle, never follows it.
//   ERR: err=1, core_rst_n=0; further input is ignored; sticky until rst.
//  boot_bypass=1 on the first post-reset cycle -> DONE directly; no writes, checksum not checked.
//  Timeout: the timer starts after the first accepted byte and clears on every accepted byte.
//   Reaching TIMEOUT idle cycles in HDR, DATA or SUM -> ERR. No timeout before the first byte.
//  Counters: the word index is wide enough for MAX_WORDS; mem_addr arithmetic wraps at ADDR_W bits.
//  Bytes offered in DONE/ERR are not consumed (in_ready=0).
// TESTING
//  N=2, bytes 02 00 00 00 | 78 56 34 12 | EF BE AD DE | chk -> two writes: @0=12345678,
//   @4=DEADBEEF; done=1; core_rst_n rises 1 cycle after the checksum byte.
//  Same frame with checksum+1 -> both writes still occur; err=1, core_rst_n stays 0, in_ready=0.
//  Header N=MAX_WORDS+1 -> ERR after the 4th header byte; mem_we never asserted.
//  N=0, header 00 00 00 00, chk=00 -> DONE with no writes. Check in_valid toggling 1/0 every cycle.
//  TIMEOUT=16: stop after 5 bytes -> err=1 on idle cycle 16. Assert rst mid-DATA -> all outputs
//   return to reset values next cycle; a full reload after that succeeds.
//  boot_bypass=1 at reset release -> core_rst_n=1 and done=1 on cycle 1 with no bytes sent.

Source files
------------

// File: rtl/boot_loader_if.sv
// Byte-stream input and RAM write port of the boot loader.
// master: byte source / RAM sink side; slave: the loader itself.
interface boot_loader_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/boot_loader.sv
// Byte-stream firmware loader: header (word count), little-endian payload words written to RAM,
// then a zero-sum checksum byte; releases the core only after the whole image is accepted.
module boot_loader #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       MAX_WORDS = 4096,
  parameter int unsigned       TIMEOUT   = 1000000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           boot_bypass,
  boot_loader_if.slave   bus,
  output logic           core_rst_n,
  output logic           done,
  output logic           err
);

  localparam int unsigned IDX_W = $clog2(MAX_WORDS + 1);

  typedef enum logic [2:0] {StHdr, StData, StSum, StDone, StErr} state_e;

  state_e              state_q, state_d;
  logic                first_q, started_q, started_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [31:0]         shift_q, shift_d;
  logic [7:0]          sum_q, sum_d;
  logic [IDX_W-1:0]    n_q, n_d, idx_q, idx_d;
  logic [31:0]         timer_q, timer_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         word;
  logic                xfer;

  // first_q marks the cycle rst deasserts: bypass is sampled then and no byte is taken.
  assign bus.in_ready = ((state_q == StHdr) && !first_q) || (state_q == StData) ||
                        (state_q == StSum);
  assign xfer         = bus.in_valid & bus.in_ready;
  assign word         = {bus.in_data, shift_q[31:8]};

  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign core_rst_n    = (state_q == StDone);
  assign done          = (state_q == StDone);
  assign err           = (state_q == StErr);

  always_comb begin
    state_d    = state_q;
    started_d  = started_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    sum_d      = sum_q;
    n_d        = n_q;
    idx_d      = idx_q;
    timer_d    = timer_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;

    if (xfer) begin
      shift_d    = word;
      byte_cnt_d = byte_cnt_q + 2'd1;
      sum_d      = sum_q + bus.in_data;
    end

    unique case (state_q)
      StHdr: begin
        if (first_q && boot_bypass) begin
          state_d = StDone;
        end else if (xfer && byte_cnt_q == 2'd3) begin
          if (word > MAX_WORDS) begin
            state_d = StErr;
          end else if (word == 32'd0) begin
            state_d = StSum;
          end else begin
            n_d     = word[IDX_W-1:0];
            idx_d   = '0;
            state_d = StData;
          end
        end
      end
      StData: begin
        if (xfer && byte_cnt_q == 2'd3) begin
          we_d    = 1'b1;
          addr_d  = BASE_ADDR + (ADDR_W'(idx_q) << 2);
          wdata_d = word;
          idx_d   = idx_q + IDX_W'(1);
          if (idx_q == n_q - IDX_W'(1)) state_d = StSum;
        end
      end
      StSum: begin
        if (xfer) state_d = (sum_d == 8'd0) ? StDone : StErr;
      end
      default: ;
    endcase

    // Idle timer: timer_q holds the index of the current idle cycle since the last byte.
    if (state_q == StHdr || state_q == StData || state_q == StSum) begin
      if (xfer) begin
        started_d = 1'b1;
        timer_d   = 32'd1;
      end else if (started_q && TIMEOUT != 0) begin
        timer_d = timer_q + 32'd1;
        if (timer_d >= TIMEOUT) state_d = StErr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StHdr;
      first_q    <= 1'b1;
      started_q  <= 1'b0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      sum_q      <= '0;
      n_q        <= '0;
      idx_q      <= '0;
      timer_q    <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      first_q    <= 1'b0;
      started_q  <= started_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      sum_q      <= sum_d;
      n_q        <= n_d;
      idx_q      <= idx_d;
      timer_q    <= timer_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: normal load, bad checksum, oversize header, empty image,
// idle timeout, mid-frame reset and boot bypass.
module tb_boot_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic boot_bypass = 1'b0;
  logic core_rst_n, done, err;
  int   tests = 0;
  int   fails = 0;
  logic [31:0] wa[$];
  logic [31:0] wd[$];

  localparam logic [103:0] FrameOk  = {8'hB2, 32'hDEADBEEF, 32'h12345678, 32'h00000002};
  localparam logic [103:0] FrameBad = {8'hB3, 32'hDEADBEEF, 32'h12345678, 32'h00000002};

  always #5 clk = ~clk;

  boot_loader_if #(.ADDR_W(32)) bus ();

  boot_loader #(
    .ADDR_W   (32),
    .BASE_ADDR(32'h0),
    .MAX_WORDS(8),
    .TIMEOUT  (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .boot_bypass(boot_bypass),
    .bus        (bus),
    .core_rst_n (core_rst_n),
    .done       (done),
    .err        (err)
  );

  always @(negedge clk) begin
    if (bus.mem_we) begin
      wa.push_back(bus.mem_addr);
      wd.push_back(bus.mem_wdata);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset(input logic bypass);
    @(negedge clk);
    rst = 1'b1;
    boot_bypass = bypass;
    @(negedge clk);
    wa.delete();
    wd.delete();
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    for (n = 0; !bus.in_ready && n < 20; n++) @(negedge clk);
    if (n == 20) check("in_ready_wait", 64'd0, 64'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic send_bytes(input logic [103:0] v, input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      send_byte(v[8*i +: 8]);
      if (gap) @(negedge clk);
    end
  endtask

  task automatic check_ok_image(input string tag);
    check({tag, "_nwr"}, 64'(wa.size()), 64'd2);
    if (wa.size() == 2) begin
      check({tag, "_a0"}, 64'(wa[0]), 64'h0);
      check({tag, "_d0"}, 64'(wd[0]), 64'h12345678);
      check({tag, "_a1"}, 64'(wa[1]), 64'h4);
      check({tag, "_d1"}, 64'(wd[1]), 64'hDEADBEEF);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_mem_we", 64'(bus.mem_we), 64'd0);
    check("rst_core_rst_n", 64'(core_rst_n), 64'd0);
    check("rst_done_err", 64'({done, err}), 64'd0);

    // Normal two-word image.
    do_reset(1'b0);
    send_bytes(FrameOk, 13, 1'b0);
    @(negedge clk);
    check("ok_core_rst_n", 64'(core_rst_n), 64'd1);
    check("ok_done_err", 64'({done, err}), 64'b10);
    check("ok_in_ready", 64'(bus.in_ready), 64'd0);
    check_ok_image("ok");
    repeat (20) @(negedge clk);
    check("ok_done_sticky", 64'({done, core_rst_n}), 64'b11);

    // Bad checksum: writes still happen, then error.
    do_reset(1'b0);
    send_bytes(FrameBad, 13, 1'b0);
    @(negedge clk);
    check("bad_done_err", 64'({done, err}), 64'b01);
    check("bad_core_rst_n", 64'(core_rst_n), 64'd0);
    check("bad_in_ready", 64'(bus.in_ready), 64'd0);
    check_ok_image("bad");

    // Oversize header (MAX_WORDS+1 = 9).
    do_reset(1'b0);
    send_bytes(104'h09, 4, 1'b0);
    @(negedge clk);
    check("big_err", 64'(err), 64'd1);
    repeat (5) @(negedge clk);
    check("big_nwr", 64'(wa.size()), 64'd0);

    // Empty image with in_valid toggling every cycle.
    do_reset(1'b0);
    send_bytes(104'h0, 5, 1'b1);
    check("empty_done_err", 64'({done, err}), 64'b10);
    check("empty_nwr", 64'(wa.size()), 64'd0);

    // Idle timeout after 5 bytes: err on idle cycle 16.
    do_reset(1'b0);
    send_bytes(104'h00_00000001, 5, 1'b0);
    repeat (15) @(negedge clk);
    check("to_err_c15", 64'(err), 64'd0);
    @(negedge clk);
    check("to_err_c16", 64'(err), 64'd1);

    // Reset mid-DATA, then a full reload.
    do_reset(1'b0);
    send_bytes(FrameOk, 9, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_in_ready", 64'(bus.in_ready), 64'd0);
    check("mid_mem", 64'({bus.mem_we, bus.mem_addr, bus.mem_wdata}), 64'd0);
    check("mid_outs", 64'({core_rst_n, done, err}), 64'd0);
    wa.delete();
    wd.delete();
    rst = 1'b0;
    send_bytes(FrameOk, 13, 1'b0);
    @(negedge clk);
    check("reload_done", 64'({done, core_rst_n}), 64'b11);
    check_ok_image("reload");

    // Boot bypass.
    do_reset(1'b1);
    @(negedge clk);
    boot_bypass = 1'b0;
    check("byp_done", 64'({done, core_rst_n, err}), 64'b110);
    check("byp_nwr", 64'(wa.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
